// File: rtl/uart_tx_fifo_param_if.sv
// Host write port of the UART transmitter.
// Valid/ready push of one data word into the TX FIFO.
interface uart_tx_fifo_param_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with TX FIFO, runtime divisor,
// parity and stop-bit selection, back-to-back frames.
module uart_tx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  uart_tx_fifo_param_if.slave           wr,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_C  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  state_t            state, state_n;
  logic [DIV_W-1:0]  cnt, cnt_n;
  logic [DIV_W-1:0]  div_q, div_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [BW-1:0]     bit_q, bit_n;
  logic              par_en_q, par_en_n;
  logic              par_odd_q, par_odd_n;
  logic              stop2_q, stop2_n;
  logic              phase_q, phase_n;
  logic              txd_n;
  logic              tick;
  logic              load;
  logic              par_bit;
  logic [DIV_W-1:0]  div_eff;

  assign wr.wr_ready = (fifo_count < DEPTH_C);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign tick        = (cnt == '0);
  assign div_eff     = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign par_bit     = par_odd_q ? ~^data_q : ^data_q;

  // FIFO storage; entries need no reset, pointers gate them
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr.wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      err_ovf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (wr.wr_valid && !wr.wr_ready)
        err_ovf <= 1'b1;
    end
  end

  // Frame sequencing, bit timing and next line level
  always_comb begin
    state_n   = state;
    cnt_n     = tick ? cnt : cnt - 1'b1;
    div_n     = div_q;
    data_n    = data_q;
    bit_n     = bit_q;
    par_en_n  = par_en_q;
    par_odd_n = par_odd_q;
    stop2_n   = stop2_q;
    phase_n   = phase_q;
    load      = 1'b0;
    pop       = 1'b0;
    txd_n     = 1'b1;

    case (state)
      IDLE: begin
        if (fifo_count != '0)
          load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          bit_n   = '0;
          cnt_n   = div_q - 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_n = div_q - 1'b1;
          if (bit_q == LAST_C) begin
            state_n = par_en_q ? PARITY : STOP;
            phase_n = 1'b0;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          phase_n = 1'b0;
          cnt_n   = div_q - 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && !phase_q) begin
            phase_n = 1'b1;
            cnt_n   = div_q - 1'b1;
          end else if (fifo_count != '0) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      pop       = 1'b1;
      state_n   = START;
      data_n    = mem[rd_ptr];
      div_n     = div_eff;
      cnt_n     = div_eff - 1'b1;
      par_en_n  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_odd_n = (cfg_parity == 2'b10);
      stop2_n   = cfg_stop2;
    end

    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = data_n[bit_n];
      PARITY:  txd_n = par_bit;
      default: txd_n = 1'b1;
    endcase
  end

  // Frame state and registered line outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      div_q     <= DIV_W'(1);
      data_q    <= '0;
      bit_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      phase_q   <= 1'b0;
      txd       <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      div_q     <= div_n;
      data_q    <= data_n;
      bit_q     <= bit_n;
      par_en_q  <= par_en_n;
      par_odd_q <= par_odd_n;
      stop2_q   <= stop2_n;
      phase_q   <= phase_n;
      txd       <= txd_n;
      busy      <= (state_n != IDLE);
    end
  end
endmodule
